// File: rtl/ysyx_25020042_pkg.sv
// Shared definitions for the ysyx_25020042 instruction fetch unit:
// FSM state encoding, the ebreak encoding and the default boot address.
package ysyx_25020042_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2,
        IFU_HALT = 2'd3
    } ifu_state_e;

    // Fetch addresses are always word aligned; low bits of a target are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ysyx_25020042_ifu.sv
// Instruction fetch unit: one outstanding memory request, a single-entry
// instruction holding register toward the decoder, redirect squashing and ebreak halt.
module ysyx_25020042_ifu
    import ysyx_25020042_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    ifu_state_e  r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic        r_run;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_halted;

    ifu_state_e  w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_drop_nxt;
    logic        w_inst_valid_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_inst_pc_nxt;
    logic        w_halted_nxt;

    logic [31:0] w_redirect_pc;
    logic        w_req_fire;

    assign w_redirect_pc = align_pc(redirect_pc);

    // r_run keeps the request line quiet until the first edge after reset release.
    assign mem_req_valid = r_run && (r_state == IFU_REQ);
    assign mem_req_addr  = r_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign halted     = r_halted;

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drop_nxt       = r_drop;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_halted_nxt     = r_halted;

        unique case (r_state)
            IFU_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end
                // A request accepted alongside a redirect fetches a stale address.
                if (w_req_fire) begin
                    w_state_nxt = IFU_WAIT;
                    w_drop_nxt  = redirect_valid;
                end
            end

            IFU_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (mem_rsp_valid) begin
                    w_drop_nxt = 1'b0;
                    if (r_drop || redirect_valid) begin
                        w_state_nxt = IFU_REQ;
                    end else begin
                        w_inst_nxt       = mem_rsp_data;
                        w_inst_pc_nxt    = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_state_nxt      = IFU_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end

            IFU_HOLD: begin
                // Redirect wins over a same-cycle consume: the held word is squashed.
                if (redirect_valid) begin
                    w_inst_valid_nxt = 1'b0;
                    w_pc_nxt         = w_redirect_pc;
                    w_state_nxt      = IFU_REQ;
                end else if (inst_ready) begin
                    w_inst_valid_nxt = 1'b0;
                    if (r_inst == EBREAK_INST) begin
                        w_halted_nxt = 1'b1;
                        w_state_nxt  = IFU_HALT;
                    end else begin
                        w_pc_nxt    = r_pc + INST_BYTES;
                        w_state_nxt = IFU_REQ;
                    end
                end
            end

            IFU_HALT: begin
                w_state_nxt = IFU_HALT;
            end

            default: begin
                w_state_nxt = IFU_REQ;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IFU_REQ;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_run        <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_run        <= 1'b1;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_halted     <= w_halted_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_25020042_ifu.sv
// Directed self-checking bench for ysyx_25020042_ifu: reset, fetch timing,
// request stalls, redirect squashing, pc wrap, reset mid-request and ebreak halt.
module tb_ysyx_25020042_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fire   = 0;

    ysyx_25020042_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Handshakes are counted mid-cycle, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) n_fire++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    // Leaves rst released at posedge+1; the next edge starts the fetch engine.
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 00000000", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h want 00000000", inst_pc); else n_pass++;
        n_checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else n_pass++;
        n_checks++; if (mem_req_addr !== 32'h8000_0000) $display("FAIL rst_pc: got %h want 80000000", mem_req_addr); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL release_quiet: got %b want 0", mem_req_valid); else n_pass++;
        tick();
        n_checks++; if (mem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b want 1", mem_req_valid); else n_pass++;
    endtask

    task automatic test_basic_fetch();
        do_reset();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        tick();
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000)
            $display("FAIL basic_req: got v=%b a=%h want v=1 a=80000000", mem_req_valid, mem_req_addr); else n_pass++;
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0013;
        n_checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL basic_wait: got req=%b iv=%b want 0 0", mem_req_valid, inst_valid); else n_pass++;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000)
            $display("FAIL basic_inst: got iv=%b i=%h pc=%h want 1 00000013 80000000", inst_valid, inst, inst_pc); else n_pass++;
        tick();
        n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004)
            $display("FAIL basic_next: got iv=%b req=%b a=%h want 0 1 80000004", inst_valid, mem_req_valid, mem_req_addr); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_ready_stall();
        int f0;
        do_reset();
        f0 = n_fire;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000)
                $display("FAIL stall_hold_%0d: got v=%b a=%h want v=1 a=80000000", i, mem_req_valid, mem_req_addr); else n_pass++;
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL stall_accept: got v=%b want 0", mem_req_valid); else n_pass++;
        mem_req_ready = 1'b1;
        repeat (3) tick();
        mem_req_ready = 1'b0;
        n_checks++; if (n_fire - f0 !== 1) $display("FAIL stall_single_accept: got %0d accepts want 1", n_fire - f0); else n_pass++;
    endtask

    task automatic test_redirect_req();
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0043;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0040)
            $display("FAIL req_redirect_addr: got v=%b a=%h want v=1 a=80000040", mem_req_valid, mem_req_addr); else n_pass++;
        mem_req_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        mem_rsp_valid  = 1'b1;
        mem_rsp_data   = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0300)
            $display("FAIL req_redirect_accept_drop: got iv=%b v=%b a=%h want 0 1 80000300", inst_valid, mem_req_valid, mem_req_addr); else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (mem_req_addr !== 32'hFFFF_FFFC) $display("FAIL align_top: got %h want fffffffc", mem_req_addr); else n_pass++;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0093;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h0000_0093)
            $display("FAIL wrap_inst: got iv=%b pc=%h i=%h want 1 fffffffc 00000093", inst_valid, inst_pc, inst); else n_pass++;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0000)
            $display("FAIL wrap_pc: got v=%b a=%h want v=1 a=00000000", mem_req_valid, mem_req_addr); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0)
                $display("FAIL wait_drop_idle_%0d: got iv=%b v=%b want 0 0", i, inst_valid, mem_req_valid); else n_pass++;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100)
            $display("FAIL wait_drop: got iv=%b v=%b a=%h want 0 1 80000100", inst_valid, mem_req_valid, mem_req_addr); else n_pass++;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0050_0093;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || inst_pc !== 32'h8000_0100)
            $display("FAIL wait_after_drop: got iv=%b i=%h pc=%h want 1 00500093 80000100", inst_valid, inst, inst_pc); else n_pass++;
    endtask

    task automatic test_hold_redirect();
        do_reset();
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0020_8113;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0020_8113 || inst_pc !== 32'h8000_0000 || mem_req_valid !== 1'b0)
                $display("FAIL hold_stable_%0d: got iv=%b i=%h pc=%h v=%b want 1 00208113 80000000 0", i, inst_valid, inst, inst_pc, mem_req_valid); else n_pass++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200)
            $display("FAIL hold_redirect: got iv=%b v=%b a=%h want 0 1 80000200", inst_valid, mem_req_valid, mem_req_addr); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        tick();
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0000_0013;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        tick();
        mem_req_ready = 1'b0;
        inst_ready    = 1'b0;
        n_checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h8000_0004)
            $display("FAIL mid_wait_setup: got v=%b a=%h want 0 80000004", mem_req_valid, mem_req_addr); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (mem_req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0)
            $display("FAIL mid_wait_async: got a=%h iv=%b v=%b want 80000000 0 0", mem_req_addr, inst_valid, mem_req_valid); else n_pass++;
        @(posedge clk);
        #1;
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000)
            $display("FAIL late_rsp_ignored: got iv=%b v=%b a=%h want 0 1 80000000", inst_valid, mem_req_valid, mem_req_addr); else n_pass++;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL fresh_wait: got iv=%b want 0", inst_valid); else n_pass++;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00A0_0513;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h00A0_0513 || inst_pc !== 32'h8000_0000)
            $display("FAIL fresh_inst: got iv=%b i=%h pc=%h want 1 00a00513 80000000", inst_valid, inst, inst_pc); else n_pass++;
    endtask

    task automatic test_ebreak_halt();
        int f0;
        do_reset();
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0073;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b1 || halted !== 1'b0)
            $display("FAIL ebreak_held: got iv=%b h=%b want 1 0", inst_valid, halted); else n_pass++;
        inst_ready = 1'b1;
        tick();
        n_checks++; if (halted !== 1'b1 || inst_valid !== 1'b0 || mem_req_valid !== 1'b0)
            $display("FAIL ebreak_halt: got h=%b iv=%b v=%b want 1 0 0", halted, inst_valid, mem_req_valid); else n_pass++;
        f0 = n_fire;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i % 3 == 0);
            redirect_pc    = 32'h8000_0500;
            mem_rsp_valid  = (i % 4 == 1);
            mem_rsp_data   = 32'h0000_0013;
            tick();
            n_checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b1)
                $display("FAIL halt_stay_%0d: got v=%b iv=%b h=%b want 0 0 1", i, mem_req_valid, inst_valid, halted); else n_pass++;
        end
        idle_inputs();
        n_checks++; if (n_fire - f0 !== 0) $display("FAIL halt_no_accept: got %0d accepts want 0", n_fire - f0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_ready_stall();
        test_redirect_req();
        test_redirect_wait();
        test_hold_redirect();
        test_reset_mid_wait();
        test_ebreak_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
